// File: rtl/riscv_pkg.sv
// Shared definitions for the single-cycle RISC-V core: fetch FSM encoding,
// the canonical NOP and the instruction size.
package riscv_pkg;

    localparam logic [2:0] ST_BOOT   = 3'd0;
    localparam logic [2:0] ST_REQ    = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_HALTED = 3'd4;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int INSTR_BYTES = 4;

    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer.sv
// Fetch/PC controller: sequences boot, fetch request, response wait and execute,
// and drives the next-PC value so the external PC register moves once per retire.
module pc_fetch_sequencer
    import riscv_pkg::*;
#(
    parameter int             N         = 32,
    parameter logic [N-1:0]   RESET_VEC = '0,
    parameter logic [N-1:0]   TRAP_VEC  = N'(32'h0000_0100),
    parameter int             CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     pc_i,
    output logic [N-1:0]     pc_next_o,
    output logic             imem_req_o,
    output logic [N-1:0]     imem_addr_o,
    input  logic             imem_ready_i,
    input  logic             imem_rvalid_i,
    input  logic [31:0]      imem_rdata_i,
    output logic [31:0]      instr_o,
    output logic             instr_valid_o,
    input  logic             core_stall_i,
    input  logic             redirect_valid_i,
    input  logic [N-1:0]     redirect_target_i,
    input  logic             halt_i,
    output logic             misalign_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] instret_o,
    output logic [2:0]       dbg_state
);

    // Memory handshake: a request transfers on a rising edge where imem_req_o and
    // imem_ready_i are both high; the response is the first imem_rvalid_i seen in
    // WAIT, and rvalid in any other state is dropped.

    logic [2:0]   state;
    logic [2:0]   state_next;
    logic         retire;
    logic         target_misaligned;
    logic [N-1:0] retire_pc;

    assign retire            = (state == ST_EXEC) && !core_stall_i;
    assign target_misaligned = redirect_valid_i && !is_word_aligned(redirect_target_i[1:0]);
    assign imem_addr_o       = pc_i;
    assign dbg_state         = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_BOOT:   state_next = ST_REQ;
            ST_REQ:    if (imem_ready_i) state_next = ST_WAIT;
            ST_WAIT:   if (imem_rvalid_i) state_next = ST_EXEC;
            ST_EXEC:   if (!core_stall_i) state_next = halt_i ? ST_HALTED : ST_REQ;
            ST_HALTED: state_next = ST_HALTED;
            default:   state_next = ST_BOOT;
        endcase
    end

    // Halt outranks any redirect; a misaligned target traps instead of truncating.
    always_comb begin
        if (halt_i) begin
            retire_pc = pc_i;
        end else if (target_misaligned) begin
            retire_pc = TRAP_VEC;
        end else if (redirect_valid_i) begin
            retire_pc = {redirect_target_i[N-1:2], 2'b00};
        end else begin
            retire_pc = pc_i + N'(INSTR_BYTES);
        end
    end

    always_comb begin
        imem_req_o    = 1'b0;
        instr_valid_o = 1'b0;
        halted_o      = 1'b0;
        pc_next_o     = pc_i;
        case (state)
            ST_BOOT: pc_next_o = RESET_VEC;
            ST_REQ:  imem_req_o = 1'b1;
            ST_WAIT: pc_next_o = pc_i;
            ST_EXEC: begin
                instr_valid_o = 1'b1;
                if (!core_stall_i) pc_next_o = retire_pc;
            end
            ST_HALTED: halted_o = 1'b1;
            default:   pc_next_o = RESET_VEC;
        endcase
        if (!rst) pc_next_o = RESET_VEC;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_o    <= NOP_INSTR;
            misalign_o <= 1'b0;
            instret_o  <= '0;
        end else begin
            if (state == ST_WAIT && imem_rvalid_i) instr_o <= imem_rdata_i;
            misalign_o <= retire && !halt_i && target_misaligned;
            if (retire) instret_o <= instret_o + CNT_W'(1);
        end
    end

endmodule
